// File: rtl/config_pkg.sv
// Shared definitions for the configuration transfer path (sender and receiver).
// Holds the UC state encoding, the config set geometry and the 7E1 frame builder.
package config_pkg;

    localparam int CONFIG_WORDS = 8;
    localparam int CONFIG_WIDTH = 7;
    localparam int FRAME_BITS   = 10;
    localparam int IDX_WIDTH    = 3;

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        CARREGA   = 4'd1,
        TRANSMITE = 4'd2,
        PROXIMO   = 4'd3,
        FIM       = 4'd4
    } uc_state_t;

    // Bit 0 goes out first: start, data LSB..MSB, even parity, stop.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [CONFIG_WIDTH-1:0] dados);
        return {1'b1, ^dados, dados, 1'b0};
    endfunction

endpackage

// File: rtl/tx_serial_7e1.sv
// Single-frame 7E1 serial transmitter: loads a frame on partida and shifts it out
// LSB first, each bit held for CLKS_PER_BIT cycles; pronto marks the final stop-bit cycle.
module tx_serial_7e1
    import config_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    partida,
    input  logic [CONFIG_WIDTH-1:0] dados,
    output logic                    saida_serial,
    output logic                    pronto
);

    localparam int                 TICK_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]         BIT_LAST  = 4'(FRAME_BITS - 1);

    logic                  ativo;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [TICK_W-1:0]     tick_cnt;
    logic [3:0]            bit_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ativo     <= 1'b0;
            shift_reg <= '1;
            tick_cnt  <= '0;
            bit_idx   <= '0;
        end else if (partida) begin
            ativo     <= 1'b1;
            shift_reg <= build_frame(dados);
            tick_cnt  <= TICK_LAST;
            bit_idx   <= '0;
        end else if (ativo) begin
            if (tick_cnt != '0) begin
                tick_cnt <= tick_cnt - TICK_W'(1);
            end else if (bit_idx == BIT_LAST) begin
                ativo <= 1'b0;
            end else begin
                shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
                bit_idx   <= bit_idx + 4'd1;
                tick_cnt  <= TICK_LAST;
            end
        end
    end

    // Gating with ativo lets an async reset force the line idle at once.
    assign saida_serial = ~ativo | shift_reg[0];
    assign pronto       = ativo && (tick_cnt == '0) && (bit_idx == BIT_LAST);

endmodule

// File: rtl/config_sender.sv
// Sends the snapshotted configuration set (temp1..temp7, lim_um) as eight 7E1 frames.
// State | meaning: INICIAL idle/sample request, CARREGA start frame, TRANSMITE wait frame, PROXIMO next word, FIM done pulse.
module config_sender
    import config_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enviar_config,
    input  logic [CONFIG_WIDTH-1:0] temp1,
    input  logic [CONFIG_WIDTH-1:0] temp2,
    input  logic [CONFIG_WIDTH-1:0] temp3,
    input  logic [CONFIG_WIDTH-1:0] temp4,
    input  logic [CONFIG_WIDTH-1:0] temp5,
    input  logic [CONFIG_WIDTH-1:0] temp6,
    input  logic [CONFIG_WIDTH-1:0] temp7,
    input  logic [CONFIG_WIDTH-1:0] lim_um,
    output logic                    saida_serial,
    output logic                    ocupado,
    output logic                    pronto_envio,
    output logic [3:0]              db_estado
);

    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(CONFIG_WORDS - 1);

    uc_state_t               state;
    uc_state_t               state_next;
    logic [IDX_WIDTH-1:0]    idx;
    logic [CONFIG_WIDTH-1:0] entradas [CONFIG_WORDS];
    logic [CONFIG_WIDTH-1:0] snapshot [CONFIG_WORDS];
    logic                    partida;
    logic                    tx_pronto;
    logic                    captura;

    assign entradas[0] = temp1;
    assign entradas[1] = temp2;
    assign entradas[2] = temp3;
    assign entradas[3] = temp4;
    assign entradas[4] = temp5;
    assign entradas[5] = temp6;
    assign entradas[6] = temp7;
    assign entradas[7] = lim_um;

    assign captura = (state == INICIAL) && enviar_config;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INICIAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = INICIAL;
        partida      = 1'b0;
        pronto_envio = 1'b0;
        case (state)
            INICIAL:   state_next = enviar_config ? CARREGA : INICIAL;
            CARREGA: begin
                partida    = 1'b1;
                state_next = TRANSMITE;
            end
            TRANSMITE: begin
                if (!tx_pronto) begin
                    state_next = TRANSMITE;
                end else if (idx == IDX_LAST) begin
                    state_next = FIM;
                end else begin
                    state_next = PROXIMO;
                end
            end
            PROXIMO:   state_next = CARREGA;
            FIM: begin
                pronto_envio = 1'b1;
                state_next   = INICIAL;
            end
            default:   state_next = INICIAL;
        endcase
    end

    // The whole set is frozen at the request so a sequence is always self-consistent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx <= '0;
            for (int i = 0; i < CONFIG_WORDS; i++) begin
                snapshot[i] <= '0;
            end
        end else if (captura) begin
            idx <= '0;
            for (int i = 0; i < CONFIG_WORDS; i++) begin
                snapshot[i] <= entradas[i];
            end
        end else if (state == PROXIMO) begin
            idx <= idx + IDX_WIDTH'(1);
        end
    end

    tx_serial_7e1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clock       (clock),
        .reset       (reset),
        .partida     (partida),
        .dados       (snapshot[idx]),
        .saida_serial(saida_serial),
        .pronto      (tx_pronto)
    );

    assign ocupado   = (state == CARREGA) || (state == TRANSMITE) || (state == PROXIMO);
    assign db_estado = state;

endmodule

// File: tb/tb_config_sender.sv
// Directed bench for config_sender: expected frames and start cycles are queued at stimulus
// time and checked by a line monitor that decodes each frame from saida_serial.
module tb_config_sender;

    localparam int CPB    = 4;
    localparam int PERIOD = 10 * CPB + 2;

    typedef struct packed {
        logic [9:0]  frame;
        logic [31:0] start;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       enviar_config;
    logic [6:0] temp1, temp2, temp3, temp4, temp5, temp6, temp7, lim_um;
    logic       saida_serial;
    logic       ocupado;
    logic       pronto_envio;
    logic [3:0] db_estado;

    logic [6:0] vals [8];
    exp_t       exp_q [$];
    exp_t       mon_exp;
    logic [9:0] mon_bits;
    int         mon_st;
    bit         mon_abort;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         e0;

    config_sender #(.CLKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .enviar_config(enviar_config),
        .temp1        (temp1),
        .temp2        (temp2),
        .temp3        (temp3),
        .temp4        (temp4),
        .temp5        (temp5),
        .temp6        (temp6),
        .temp7        (temp7),
        .lim_um       (lim_um),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .pronto_envio (pronto_envio),
        .db_estado    (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_vals(input logic [6:0] a, b, c, d, e, f, g, h);
        vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
        vals[4] = e; vals[5] = f; vals[6] = g; vals[7] = h;
        temp1 = a; temp2 = b; temp3 = c; temp4 = d;
        temp5 = e; temp6 = f; temp7 = g; lim_um = h;
    endtask

    task automatic push_seq(input int base);
        for (int i = 0; i < 8; i++) begin
            exp_t x;
            x.frame = {1'b1, ^vals[i], vals[i], 1'b0};
            x.start = 32'(base + 1 + i * PERIOD);
            exp_q.push_back(x);
        end
    endtask

    // Raises the request, queues the expected sequence, and checks the first two UC states.
    task automatic start_seq(output int base, input bit hold);
        @(negedge clock);
        enviar_config = 1'b1;
        base = cyc + 1;
        push_seq(base);
        @(negedge clock);
        check("db_carrega", 32'(db_estado), 32'd1);
        check("ocupado_carrega", 32'(ocupado), 32'd1);
        if (!hold) enviar_config = 1'b0;
        @(negedge clock);
        check("db_transmite", 32'(db_estado), 32'd2);
    endtask

    task automatic wait_done(input int base, input int until_rel);
        int n = 0;
        int at = -1;
        while (cyc < base + until_rel) begin
            @(negedge clock);
            if (pronto_envio) begin
                n++;
                at = cyc;
            end
            if (cyc == base + 334) check("ocupado_before_done", 32'(ocupado), 32'd1);
            if (cyc == base + 335) check("ocupado_at_done", 32'(ocupado), 32'd0);
        end
        check("done_pulses", 32'(n), 32'd1);
        check("done_cycle", 32'(at), 32'(base + 335));
    endtask

    // Line monitor: start bit seen at the negedge of its first cycle, then one sample per bit.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && saida_serial === 1'b0) begin
                mon_st    = cyc;
                mon_bits  = '0;
                mon_abort = 1'b0;
                for (int k = 1; k < 10; k++) begin
                    repeat (CPB) @(negedge clock);
                    if (reset) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    mon_bits[k] = saida_serial;
                end
                if (!mon_abort) begin
                    check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        mon_exp = exp_q.pop_front();
                        check("frame_bits", 32'(mon_bits), 32'(mon_exp.frame));
                        check("frame_start", 32'(mon_st), mon_exp.start);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        enviar_config = 1'b0;
        set_vals(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
        repeat (3) @(negedge clock);
        check("reset_outputs", 32'({saida_serial, ocupado, pronto_envio, db_estado}),
              32'({1'b1, 1'b0, 1'b0, 4'd0}));
        reset = 1'b0;

        // Idle with no request.
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("idle", 32'({saida_serial, ocupado, db_estado}), 32'({1'b1, 1'b0, 4'd0}));
        end

        // Full sequence with distinct values; temp1/temp2 give the reference frames.
        set_vals(7'h41, 7'h43, 7'h15, 7'h7F, 7'h00, 7'h2A, 7'h55, 7'h6C);
        start_seq(e0, 1'b0);
        wait_done(e0, 400);
        check("queue_drained_full", 32'(exp_q.size()), 32'd0);

        // Input change and request toggles mid-sequence must not matter.
        set_vals(7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08);
        start_seq(e0, 1'b0);
        while (cyc < e0 + 10) @(negedge clock);
        temp3 = 7'h7E;
        while (cyc < e0 + 20) @(negedge clock);
        enviar_config = 1'b1;
        repeat (2) @(negedge clock);
        enviar_config = 1'b0;
        wait_done(e0, 400);
        check("queue_drained_snapshot", 32'(exp_q.size()), 32'd0);

        // Request held through FIM restarts right after the return to INICIAL.
        set_vals(7'h3C, 7'h5A, 7'h66, 7'h0F, 7'h70, 7'h12, 7'h24, 7'h48);
        start_seq(e0, 1'b1);
        push_seq(e0 + 337);
        wait_done(e0, 336);
        @(negedge clock);
        check("restart_db", 32'(db_estado), 32'd1);
        enviar_config = 1'b0;
        wait_done(e0 + 337, 400);
        check("queue_drained_restart", 32'(exp_q.size()), 32'd0);

        // Reset during frame 4 data (temp4 bit 2 = 0 is on the line at e0+140).
        set_vals(7'h11, 7'h22, 7'h33, 7'h10, 7'h44, 7'h55, 7'h66, 7'h77);
        start_seq(e0, 1'b0);
        while (cyc < e0 + 140) @(negedge clock);
        check("line_before_reset", 32'(saida_serial), 32'd0);
        reset = 1'b1;
        #1;
        check("line_on_reset", 32'(saida_serial), 32'd1);
        check("state_on_reset", 32'({ocupado, db_estado}), 32'({1'b0, 4'd0}));
        repeat (5) @(negedge clock);
        exp_q.delete();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("line_after_reset", 32'(saida_serial), 32'd1);
        start_seq(e0, 1'b0);
        wait_done(e0, 400);
        check("queue_drained_after_reset", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/config_sender.md
# config_sender

Serial transmitter for the configuration set: it sends the seven temperature thresholds and the humidity limit back over the serial line, one parity-protected frame per value. The order (temp1..temp7, then lim_um) is the same order the configuration receiver loads them. Host readback uses it after a configuration, and it also drives board-to-board config transfer. It sits beside the config receiver and reads the same config registers.

## Interface
Parameters:
- CLKS_PER_BIT, default 5208: clock cycles per serial bit (50 MHz / 9600 baud). Must be ≥ 2.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- enviar_config  in  1  start request, level-sampled in INICIAL
- temp1 … temp7  in  7 each  temperature thresholds
- lim_um  in  7  humidity limit
- saida_serial  out  1  serial line, idle high
- ocupado  out  1  high while a transmission is in progress
- pronto_envio  out  1  one-cycle pulse when all 8 frames are sent
- db_estado  out  4  current UC state, for debug display

## Operation
- Frame format (7E1), LSB first: start bit 0, data[0..6], parity = ^data (even), stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles, so a frame is 10·CLKS_PER_BIT cycles.
- UC states and db_estado encoding:
  - INICIAL = 0: if enviar_config, snapshot all 8 inputs into internal registers, set idx = 0, go to CARREGA. Otherwise stay.
  - CARREGA = 1: pulse partida to the frame transmitter with snapshot[idx]. Go to TRANSMITE.
  - TRANSMITE = 2: wait for tx_pronto. On tx_pronto, go to FIM if idx == 7, otherwise go to PROXIMO.
  - PROXIMO = 3: idx <= idx + 1, go to CARREGA.
  - FIM = 4: assert pronto_envio, go to INICIAL unconditionally.
  - Any other value: go to INICIAL.
- ocupado = state ∈ {CARREGA, TRANSMITE, PROXIMO}.
- Values are taken from the snapshot only. Input changes during a transmission have no effect.
- enviar_config is ignored outside INICIAL. If it is still high after FIM, a new transmission starts from INICIAL on the next cycle.
- idx is 3 bits. It never wraps during a sequence.

## Timing
- Reset values: state INICIAL, saida_serial 1, ocupado 0, pronto_envio 0, db_estado 0, idx 0, tx counters 0.
- Reset asserted mid-frame: the line returns to 1 immediately (asynchronous). No partial frame resumes.
- Let e0 be the edge that samples enviar_config in INICIAL.
  - CARREGA occupies cycle e0.
  - The start bit drives the line from edge e0+1.
- tx_pronto is high during the last cycle of the stop bit.
- Between frames the line stays at 1 for the stop bit plus 2 extra cycles (PROXIMO and CARREGA). The frame period is therefore 10·CLKS_PER_BIT + 2 cycles.
- pronto_envio is high during the cycle that starts at edge e0 + 80·CLKS_PER_BIT + 15. With CLKS_PER_BIT = 4 this is e0 + 335.
- The line is high whenever the block is not in a frame's start, data or parity bit.

## Structure
- Shared package (config_pkg): state encodings, CONFIG_WORDS = 8, CONFIG_WIDTH = 7, frame bit count = 10. Shared with the receiver side.
- Sub-module tx_serial_7e1 handles the bit timing for one frame.
  - Inputs: clock, reset, partida, dados[6:0].
  - Outputs: saida_serial, pronto.
  - Internals: bit-tick counter, 4-bit bit index, 10-bit shift register loaded on partida.
- The top level holds the UC, idx, the 8×7 snapshot registers and the mux.

## Test plan
All scenarios use CLKS_PER_BIT = 4.
1. After reset, hold enviar_config = 0 for 100 cycles -> saida_serial = 1, ocupado = 0, db_estado = 0 throughout.
2. Set temp1 = 7'h41 and pulse enviar_config -> the first frame, sampled every 4 cycles, reads 0,1,0,0,0,0,0,1,0,1 (parity 0).
3. Set temp2 = 7'h43 -> the second frame starts 42 cycles after the first and reads 0,1,1,0,0,0,0,1,1,1 (parity 1).
4. Load distinct values in temp1..lim_um and run a full sequence -> 8 frames in order, pronto_envio is a single pulse at e0 + 335, and ocupado falls in the same cycle.
5. Change temp3 during frame 1 and toggle enviar_config during transmission -> frame 3 carries the old snapshot value and no restart occurs.
6. Assert reset during frame 4's data bits -> the line goes to 1 immediately and the state returns to INICIAL. A new enviar_config then sends all 8 frames from temp1.
